// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam int         TAIL  = MEM_LATENCY - 1;

  logic [3:0]             starve_cnt;
  logic                   starved;
  // One tag per in-flight read; own_pipe=1 marks a data-port read.
  logic [MEM_LATENCY-1:0] vld_pipe;
  logic [MEM_LATENCY-1:0] own_pipe;

  always_comb begin
    starved = (starve_cnt == LIMIT);
    d_gnt   = !rst && d_req && !(i_req && starved);
    i_gnt   = !rst && i_req && !d_gnt;
  end

  always_comb begin
    mem_req   = i_gnt || d_gnt;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  // A flush also kills the fetch tag leaving the pipe this cycle.
  always_comb begin
    i_rvalid = !rst && vld_pipe[TAIL] && !own_pipe[TAIL] && !i_flush;
    d_rvalid = !rst && vld_pipe[TAIL] &&  own_pipe[TAIL];
    i_rdata  = rst ? '0 : mem_rdata;
    d_rdata  = rst ? '0 : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      vld_pipe   <= '0;
      own_pipe   <= '0;
    end else begin
      if (i_gnt || !i_req)
        starve_cnt <= '0;
      else if (d_gnt && !starved)
        starve_cnt <= starve_cnt + 4'd1;
      vld_pipe[0] <= mem_req && (mem_we == 4'b0000);
      own_pipe[0] <= d_gnt;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] && !(i_flush && !own_pipe[k-1]);
        own_pipe[k] <= own_pipe[k-1];
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency unified memory between the instruction fetch port and the data access port of the RV32IM five-stage pipeline. The data port has priority, and a starvation counter guarantees forward progress for fetch. Each port gets a same-cycle grant and a tagged, in-order read response. It sits between the IF/MEM stages and the memory, and replaces the separate instruction and data memory ports when a unified memory is used.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from an accepted memory read to `mem_rdata` being valid. Legal range 1–4.
- `STARVE_LIMIT`, default 4: consecutive cycles fetch may lose arbitration before it is forced to win. Legal range 1–15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `i_req` input 1: fetch request; held until granted.
- `i_addr` input 32: fetch word address.
- `i_flush` input 1: discard fetch reads granted in earlier cycles.
- `i_gnt` output 1: fetch request accepted this cycle.
- `i_rvalid` output 1: `i_rdata` valid this cycle.
- `i_rdata` output 32: fetch read data.
- `d_req` input 1: data request; held until granted.
- `d_addr` input 32: data address.
- `d_we` input 4: byte write enables; 4'b0000 means read.
- `d_wdata` input 32: store data.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: `d_rdata` valid this cycle (loads only).
- `d_rdata` output 32: load data.
- `mem_req` output 1: memory access this cycle.
- `mem_addr` output 32: memory address.
- `mem_we` output 4: memory byte enables.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory read data, valid `MEM_LATENCY` cycles after a read.

## Operation
- **Grant logic.** At most one grant per cycle.
  - `d_req` only: `d_gnt`=1.
  - `i_req` only: `i_gnt`=1.
  - Both asserted: data wins, unless `starve_cnt`==`STARVE_LIMIT`, in which case fetch wins.
- **Memory mux.** `mem_req`=`i_gnt`|`d_gnt`. `mem_addr`, `mem_we` and `mem_wdata` come from the granted port. A fetch drives `mem_we`=0. With no grant, `mem_*` outputs are 0.
- **Starvation counter.** `starve_cnt` width is 4.
  - Increments (saturating at `STARVE_LIMIT`) when `i_req` & `d_gnt`.
  - Clears when `i_gnt` or !`i_req`.
- **Response tracking.** A tag pipeline `MEM_LATENCY` deep; each entry holds {valid, owner}.
  - Stage 0 is loaded with valid = `mem_req` & (`mem_we`==0), owner = I or D.
  - At the pipeline tail: `i_rvalid` = valid & owner==I; `d_rvalid` = valid & owner==D.
- **Read data.** `i_rdata` and `d_rdata` are both driven by `mem_rdata`. Consumers qualify with their rvalid.
- **Writes.** A write completes at grant; it produces no rvalid.
- **Fetch flush.** `i_flush`=1 clears the valid bit of every owner==I tag already in the pipeline, including the one exiting this cycle, so `i_rvalid`=0 this cycle.
  - A fetch granted in the same cycle as `i_flush` is not killed.
  - Data tags are unaffected.
- **Reset.** Clears all tags and `starve_cnt`. A response pending at reset is never signalled.

## Timing
- `i_gnt`, `d_gnt` and all `mem_*` outputs are combinational from the same-cycle requests and `starve_cnt`. There is no registered path from req to gnt.
- A read granted in cycle N gives rvalid in cycle N+`MEM_LATENCY`. Back-to-back grants give back-to-back responses, in order, at one per cycle maximum.
- Requester contract: `*_addr`, `d_we` and `d_wdata` are stable while `*_req`=1 and not granted. A requester may drop req only after gnt.
- Reset values (cycle after `rst`=1):
  - `i_rvalid`=`d_rvalid`=0.
  - `starve_cnt`=0.
  - `i_gnt`, `d_gnt` and `mem_*` follow the grant rules with `starve_cnt`=0.
  - While `rst`=1, all outputs are forced to 0.
- Boundary conditions:
  - `STARVE_LIMIT` reached and `d_req` absent: ordinary fetch grant; the counter clears.
  - `i_flush` with no fetch tags in flight: no effect.
  - `rst` mid-response: the tail tag is discarded and rvalid stays 0.

## Test plan
- **Data priority.** `MEM_LATENCY`=1; `i_req`=`d_req`=1 in cycle 0 with `d_addr`=0x100, `d_we`=0 → cycle 0: `d_gnt`=1, `i_gnt`=0, `mem_addr`=0x100. Cycle 1: `d_rvalid`=1, `d_rdata`=`mem_rdata`.
- **Starvation.** `STARVE_LIMIT`=4; `i_req` and `d_req` held high continuously → `d_gnt` in cycles 0–3, `i_gnt` in cycle 4, `d_gnt` resumes in cycle 5. The pattern repeats every 5 cycles.
- **Pipelined reads.** `MEM_LATENCY`=3; fetch grants at 0x0, 0x4, 0x8 in cycles 0–2 → `i_rvalid`=1 in cycles 3–5, matching memory data 0x11, 0x22, 0x33 in order.
- **Flush.** `MEM_LATENCY`=2; fetch grants in cycles 0 and 1, and `i_flush`=1 in cycle 1 → `i_rvalid`=0 in cycle 2. `i_rvalid`=1 in cycle 3 for the cycle-1 fetch. An in-flight data load is still returned.
- **Store.** `d_req`=1, `d_we`=4'b0011, `d_wdata`=0xDEADBEEF, `d_addr`=0x200 → same cycle `mem_we`=4'b0011, `mem_wdata`=0xDEADBEEF; `d_rvalid` is never asserted.
- **Reset mid-read.** A load is granted in cycle 0 with `MEM_LATENCY`=2, and `rst`=1 in cycle 1 → `d_rvalid`=0 in cycles 1–3; `starve_cnt`=0 afterward.
